// File: rtl/mem_stage_p.sv
// Pipeline MEM stage: forwards ALU results, issues store/load strobes to the data
// cache, stalls on load misses until refill, and counts misses.
module mem_stage_p #(
  parameter int unsigned DW    = 16,
  parameter int unsigned IRW   = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             mem_valid,
  input  logic [IRW-1:0]   mem_ir,
  input  logic             mem_load,
  input  logic             mem_store,
  input  logic [DW-1:0]    reg_c,
  input  logic [DW-1:0]    smdr,
  input  logic             d_hit,
  input  logic [DW-1:0]    d_rdata,
  input  logic             d_ready,
  input  logic             cnt_clr,
  output logic [DW-1:0]    d_addr,
  output logic [DW-1:0]    d_dataout,
  output logic             d_we,
  output logic             d_re,
  output logic             stall,
  output logic [IRW-1:0]   wb_ir,
  output logic [DW-1:0]    wb_result,
  output logic             wb_valid,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [IRW-1:0]   r_hold_ir;
  logic [IRW-1:0]   r_wb_ir;
  logic [DW-1:0]    r_wb_result;
  logic             r_wb_valid;
  logic [CNT_W-1:0] r_miss_count;

  logic w_go;
  logic w_miss;
  logic w_load_miss;

  // Strobes are gated by reset so nothing reaches the cache while it is held.
  assign w_go        = (r_state == S_IDLE) & en & mem_valid & reset;
  assign w_miss      = (r_state == S_MISS);
  assign w_load_miss = w_go & mem_load & ~d_hit;

  assign d_addr    = reg_c;
  assign d_dataout = smdr;
  assign d_we      = w_go & mem_store;
  assign d_re      = (w_go & mem_load) | w_miss;
  assign stall     = w_load_miss | (w_miss & ~d_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hold_ir   <= '0;
      r_wb_ir     <= '0;
      r_wb_result <= '0;
      r_wb_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            if (!mem_valid) begin
              r_wb_valid <= 1'b0;
            end else if (mem_load && !d_hit) begin
              r_state    <= S_MISS;
              r_hold_ir  <= mem_ir;
              r_wb_valid <= 1'b0;
            end else begin
              r_wb_ir     <= mem_ir;
              r_wb_result <= mem_load ? d_rdata : reg_c;
              r_wb_valid  <= 1'b1;
            end
          end
        end
        S_MISS: begin
          // Upstream is frozen, so the refill completes from the held instruction.
          if (d_ready) begin
            r_state     <= S_IDLE;
            r_wb_ir     <= r_hold_ir;
            r_wb_result <= d_rdata;
            r_wb_valid  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating miss counter; clear has priority over increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_miss_count <= '0;
    end else if (cnt_clr) begin
      r_miss_count <= '0;
    end else if (w_load_miss && (r_miss_count != CNT_MAX)) begin
      r_miss_count <= r_miss_count + CNT_W'(1);
    end
  end

  assign wb_ir      = r_wb_ir;
  assign wb_result  = r_wb_result;
  assign wb_valid   = r_wb_valid;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_mem_stage_p.sv
// Self-checking bench for mem_stage_p: directed scenarios plus randomized traffic
// compared against a transaction-level model with a pending-miss queue.
module tb_mem_stage_p;

  localparam int unsigned DW    = 16;
  localparam int unsigned IRW   = 16;
  localparam int unsigned CNT_W = 4;

  logic             clock;
  logic             reset;
  logic             en;
  logic             mem_valid;
  logic [IRW-1:0]   mem_ir;
  logic             mem_load;
  logic             mem_store;
  logic [DW-1:0]    reg_c;
  logic [DW-1:0]    smdr;
  logic             d_hit;
  logic [DW-1:0]    d_rdata;
  logic             d_ready;
  logic             cnt_clr;
  logic [DW-1:0]    d_addr;
  logic [DW-1:0]    d_dataout;
  logic             d_we;
  logic             d_re;
  logic             stall;
  logic [IRW-1:0]   wb_ir;
  logic [DW-1:0]    wb_result;
  logic             wb_valid;
  logic [CNT_W-1:0] miss_count;

  int checks = 0;
  int errors = 0;

  mem_stage_p #(.DW(DW), .IRW(IRW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .en(en), .mem_valid(mem_valid), .mem_ir(mem_ir),
    .mem_load(mem_load), .mem_store(mem_store), .reg_c(reg_c), .smdr(smdr),
    .d_hit(d_hit), .d_rdata(d_rdata), .d_ready(d_ready), .cnt_clr(cnt_clr),
    .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_re(d_re), .stall(stall),
    .wb_ir(wb_ir), .wb_result(wb_result), .wb_valid(wb_valid), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    en = 1'b0; mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
    d_hit = 1'b0; d_ready = 1'b0; cnt_clr = 1'b0;
    mem_ir = '0; reg_c = '0; smdr = '0; d_rdata = '0;
  endtask

  task automatic test_reset;
    // A load-miss request is presented during reset; nothing may be issued.
    en = 1'b1; mem_valid = 1'b1; mem_load = 1'b1; mem_store = 1'b0; d_hit = 1'b0;
    #1;
    checks++;
    if ({d_we, d_re, stall} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got we/re/stall=%b want 000", {d_we, d_re, stall});
    end
    checks++;
    if ({wb_ir, wb_result, wb_valid, miss_count} !== '0) begin
      errors++; $display("FAIL reset_regs got ir=%h res=%h v=%b cnt=%h want all 0",
                         wb_ir, wb_result, wb_valid, miss_count);
    end
    idle_inputs();
  endtask

  task automatic test_passthrough;
    en = 1'b1; mem_valid = 1'b1; reg_c = 16'h1234; mem_ir = 16'h0800;
    #1;
    checks++;
    if ({d_we, d_re, stall} !== 3'b000) begin
      errors++; $display("FAIL alu_strobes got we/re/stall=%b want 000", {d_we, d_re, stall});
    end
    tick();
    checks++;
    if (wb_result !== 16'h1234 || wb_ir !== 16'h0800 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL alu_wb got res=%h ir=%h v=%b want 1234 0800 1", wb_result, wb_ir, wb_valid);
    end
    // Bubble: valid drops, payload holds.
    mem_valid = 1'b0; reg_c = 16'h9999; mem_ir = 16'h7777;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_result !== 16'h1234 || wb_ir !== 16'h0800) begin
      errors++; $display("FAIL bubble got res=%h ir=%h v=%b want 1234 0800 0", wb_result, wb_ir, wb_valid);
    end
    // en=0 freezes everything, even with a valid instruction offered.
    en = 1'b0; mem_valid = 1'b1; mem_store = 1'b1;
    #1;
    checks++;
    if ({d_we, d_re, stall} !== 3'b000) begin
      errors++; $display("FAIL en0_strobes got we/re/stall=%b want 000", {d_we, d_re, stall});
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_result !== 16'h1234) begin
      errors++; $display("FAIL en0_hold got res=%h v=%b want 1234 0", wb_result, wb_valid);
    end
    idle_inputs();
  endtask

  task automatic test_load_hit;
    en = 1'b1; mem_valid = 1'b1; mem_load = 1'b1; d_hit = 1'b1; d_rdata = 16'hBEEF;
    mem_ir = 16'h2100; reg_c = 16'h0010;
    d_ready = 1'b1; // ignored in IDLE
    #1;
    checks++;
    if (d_re !== 1'b1 || stall !== 1'b0 || d_we !== 1'b0) begin
      errors++; $display("FAIL hit_strobes got re=%b stall=%b we=%b want 1 0 0", d_re, stall, d_we);
    end
    tick();
    checks++;
    if (wb_result !== 16'hBEEF || wb_valid !== 1'b1 || wb_ir !== 16'h2100) begin
      errors++; $display("FAIL hit_wb got res=%h ir=%h v=%b want BEEF 2100 1", wb_result, wb_ir, wb_valid);
    end
    idle_inputs();
  endtask

  task automatic test_store;
    en = 1'b1; mem_valid = 1'b1; mem_store = 1'b1; d_hit = 1'b0;
    reg_c = 16'h0040; smdr = 16'h5A5A; mem_ir = 16'h3300;
    #1;
    checks++;
    if (d_we !== 1'b1 || d_re !== 1'b0 || stall !== 1'b0 || d_addr !== 16'h0040 || d_dataout !== 16'h5A5A) begin
      errors++; $display("FAIL store_strobes got we=%b re=%b stall=%b addr=%h dout=%h want 1 0 0 0040 5A5A",
                         d_we, d_re, stall, d_addr, d_dataout);
    end
    tick();
    checks++;
    if (wb_result !== 16'h0040 || wb_valid !== 1'b1 || miss_count !== 4'h0) begin
      errors++; $display("FAIL store_wb got res=%h v=%b cnt=%h want 0040 1 0", wb_result, wb_valid, miss_count);
    end
    idle_inputs();
  endtask

  task automatic test_load_miss;
    int stall_cycles = 0;
    mem_valid = 1'b1; mem_load = 1'b1; d_hit = 1'b0; mem_ir = 16'h4A5B; reg_c = 16'h0200;
    for (int c = 0; c <= 4; c++) begin
      en      = (c == 0);  // miss progression must not depend on en
      d_ready = (c == 4);
      d_rdata = (c == 4) ? 16'hCAFE : 16'($urandom);
      #1;
      if (stall === 1'b1) stall_cycles++;
      if (c > 0) begin
        checks++;
        if (wb_valid !== 1'b0 || d_re !== 1'b1) begin
          errors++; $display("FAIL miss_cycle%0d got v=%b re=%b want 0 1", c, wb_valid, d_re);
        end
      end
      tick();
    end
    checks++;
    if (stall_cycles != 4) begin
      errors++; $display("FAIL miss_stall_len got %0d want 4", stall_cycles);
    end
    checks++;
    if (wb_result !== 16'hCAFE || wb_ir !== 16'h4A5B || wb_valid !== 1'b1 || miss_count !== 4'h1) begin
      errors++; $display("FAIL miss_wb got res=%h ir=%h v=%b cnt=%h want CAFE 4A5B 1 1",
                         wb_result, wb_ir, wb_valid, miss_count);
    end
    idle_inputs();
  endtask

  task automatic one_miss(input logic clr);
    en = 1'b1; mem_valid = 1'b1; mem_load = 1'b1; d_hit = 1'b0; cnt_clr = clr;
    tick();
    cnt_clr = 1'b0; en = 1'b0; d_ready = 1'b1; d_rdata = 16'h0101;
    tick();
    idle_inputs();
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 16; i++) one_miss(1'b0);
    checks++;
    if (miss_count !== 4'hF) begin
      errors++; $display("FAIL sat_count got %h want F", miss_count);
    end
    one_miss(1'b1);
    checks++;
    if (miss_count !== 4'h0 || wb_valid !== 1'b1 || wb_result !== 16'h0101) begin
      errors++; $display("FAIL clr_wins got cnt=%h v=%b res=%h want 0 1 0101", miss_count, wb_valid, wb_result);
    end
  endtask

  task automatic test_reset_mid_miss;
    en = 1'b1; mem_valid = 1'b1; mem_load = 1'b1; d_hit = 1'b0; mem_ir = 16'h6060;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({wb_ir, wb_result, wb_valid, miss_count, d_we, d_re, stall} !== '0) begin
      errors++; $display("FAIL rst_mid got ir=%h res=%h v=%b cnt=%h we=%b re=%b stall=%b want all 0",
                         wb_ir, wb_result, wb_valid, miss_count, d_we, d_re, stall);
    end
    tick();
    idle_inputs();
    reset = 1'b1;
    d_ready = 1'b1; // stale refill after reset must be ignored
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_ir !== '0) begin
      errors++; $display("FAIL rst_release got v=%b ir=%h want 0 0000", wb_valid, wb_ir);
    end
    d_ready = 1'b0; en = 1'b1; mem_valid = 1'b1; reg_c = 16'hA5C3; mem_ir = 16'h0900;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_result !== 16'hA5C3 || wb_ir !== 16'h0900) begin
      errors++; $display("FAIL rst_after_alu got res=%h ir=%h v=%b want A5C3 0900 1", wb_result, wb_ir, wb_valid);
    end
    idle_inputs();
  endtask

  // Transaction model: a queue holds the instruction of an outstanding miss.
  task automatic test_random;
    logic [IRW-1:0]   pend_q[$];
    logic [IRW-1:0]   m_ir = '0;
    logic [DW-1:0]    m_res = '0;
    logic             m_valid = 1'b0;
    int               m_cnt = 0;
    logic             in_miss, go, e_we, e_re, e_stall, missed;
    int               kind;
    reset = 1'b0; idle_inputs(); tick(); reset = 1'b1; tick();
    for (int n = 0; n < 600; n++) begin
      in_miss = (pend_q.size() != 0);
      en = 1'($urandom_range(0, 3) != 0);
      if (!in_miss) begin
        mem_valid = 1'($urandom_range(0, 4) != 0);
        kind = $urandom_range(0, 2);
        mem_load = (kind == 1); mem_store = (kind == 2);
        mem_ir = 16'($urandom); reg_c = 16'($urandom); smdr = 16'($urandom);
        d_hit = 1'($urandom_range(0, 1));
      end
      d_ready = 1'($urandom_range(0, 2) == 0);
      d_rdata = 16'($urandom);
      cnt_clr = 1'($urandom_range(0, 24) == 0);
      #1;
      go      = !in_miss && en && mem_valid;
      e_we    = go && mem_store;
      e_re    = (go && mem_load) || in_miss;
      e_stall = (go && mem_load && !d_hit) || (in_miss && !d_ready);
      checks++;
      if ({d_we, d_re, stall} !== {e_we, e_re, e_stall} || d_addr !== reg_c || d_dataout !== smdr) begin
        errors++; $display("FAIL rand_comb n=%0d got we/re/stall=%b addr=%h dout=%h want %b %h %h",
                           n, {d_we, d_re, stall}, d_addr, d_dataout, {e_we, e_re, e_stall}, reg_c, smdr);
      end
      missed = 1'b0;
      if (in_miss) begin
        if (d_ready) begin
          m_ir = pend_q.pop_front(); m_res = d_rdata; m_valid = 1'b1;
        end
      end else if (en) begin
        if (!mem_valid) m_valid = 1'b0;
        else if (mem_load && !d_hit) begin
          pend_q.push_back(mem_ir); m_valid = 1'b0; missed = 1'b1;
        end else begin
          m_ir = mem_ir; m_res = mem_load ? d_rdata : reg_c; m_valid = 1'b1;
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (missed && m_cnt < 15) m_cnt++;
      tick();
      checks++;
      if (wb_ir !== m_ir || wb_result !== m_res || wb_valid !== m_valid || miss_count !== 4'(m_cnt)) begin
        errors++; $display("FAIL rand_wb n=%0d got ir=%h res=%h v=%b cnt=%h want %h %h %b %h",
                           n, wb_ir, wb_result, wb_valid, miss_count, m_ir, m_res, m_valid, 4'(m_cnt));
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_passthrough();
    test_load_hit();
    test_store();
    test_load_miss();
    test_saturation();
    test_reset_mid_miss();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
